// File: rtl/rgmii_phy_rx_gen_if.sv
// Byte-stream handshake into the RGMII receive-path generator.
//   in_data  : frame byte, low nibble goes out first
//   in_valid : byte valid; contiguous accepted beats form one frame
//   in_er    : receive-error flag for in_data, qualified by in_valid
//   in_ready : one-cycle accept strobe from the generator
interface rgmii_phy_rx_gen_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_er;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_er, input in_ready);
    modport slave  (input in_data, input in_valid, input in_er, output in_ready);
endinterface

// File: rtl/rgmii_phy_rx_gen.sv
// PHY-side RGMII receive-path generator. Serialises a byte stream into
// per-clock DDR half pairs (RXC / RD / RX_CTL) for an external 6-bit oddr,
// at 1G, 100M or 10M, with in-band link status between frames and a
// minimum inter-frame gap.
// Ports:
//   clk, rst_n            125 MHz clock, asynchronous active-low reset
//   in_if (slave)         byte stream in: in_data/in_valid/in_er, in_ready out
//   speed                 2'b10 1G, 2'b01 100M, 2'b00 10M (2'b11 runs as 1G)
//   link_up, full_duplex  in-band status bits
//   rxc_d1/d2, rd_d1/d2,
//   rx_ctl_d1/d2          rising-half / falling-half values per clk
//   busy                  high while a frame or its gap is in progress
module rgmii_phy_rx_gen #(
    parameter bit INBAND_STATUS = 1'b1,
    parameter int MIN_IFG       = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    rgmii_phy_rx_gen_if.slave   in_if,
    input  logic [1:0]          speed,
    input  logic                link_up,
    input  logic                full_duplex,
    output logic                rxc_d1,
    output logic                rxc_d2,
    output logic [3:0]          rd_d1,
    output logic [3:0]          rd_d2,
    output logic                rx_ctl_d1,
    output logic                rx_ctl_d2,
    output logic                busy
);
    localparam logic [7:0] IFG_LAST = 8'(MIN_IFG - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, IFG = 2'd2} state_t;

    state_t     state_q, state_n;
    logic [5:0] cnt_q, cnt_n, cnt_last;
    logic       half_q, half_n;      // 0: low-nibble period, 1: high-nibble period
    logic [1:0] spd_q, spd_n;
    logic [7:0] byte_q, byte_n;
    logic       dv_q, dv_n, er_q, er_n;
    logic [7:0] ifg_q, ifg_n;
    logic       run_q;               // blocks accepts on the first cycle out of reset
    logic       wrap, tick, accept;

    logic       rxc1_n, rxc2_n, ctl1_n, ctl2_n;
    logic [3:0] rd1_n, rd2_n, nib, status;

    function automatic logic [5:0] period_last(input logic [1:0] s);
        case (s)
            2'b01:   return 6'd4;
            2'b00:   return 6'd49;
            default: return 6'd0;
        endcase
    endfunction

    assign cnt_last        = period_last(spd_q);
    assign wrap            = (cnt_q == cnt_last);
    // a byte period is two counter periods at 10/100, one clock at 1G
    assign tick            = spd_q[1] | (wrap & half_q);
    assign in_if.in_ready  = run_q & tick & (state_q != IFG);
    assign accept          = in_if.in_ready & in_if.in_valid;
    assign busy            = (state_q != IDLE);

    always_comb begin
        state_n = state_q;
        cnt_n   = wrap ? 6'd0 : cnt_q + 6'd1;
        half_n  = wrap ? ~half_q : half_q;
        spd_n   = spd_q;
        byte_n  = byte_q;
        dv_n    = dv_q;
        er_n    = er_q;
        ifg_n   = ifg_q;

        // speed only retunes between frames; half restarts so the next
        // byte period begins cleanly at the new rate
        if (state_q == IDLE && wrap && speed != spd_q) begin
            spd_n  = speed;
            half_n = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = FRAME;
                    byte_n  = in_if.in_data;
                    er_n    = in_if.in_er;
                    dv_n    = 1'b1;
                end
            end
            FRAME: begin
                if (accept) begin
                    byte_n = in_if.in_data;
                    er_n   = in_if.in_er;
                end else if (tick) begin
                    state_n = IFG;
                    dv_n    = 1'b0;
                    er_n    = 1'b0;
                    ifg_n   = 8'd0;
                end
            end
            IFG: begin
                if (tick) begin
                    if (ifg_q == IFG_LAST) state_n = IDLE;
                    else if (ifg_q != 8'hFF) ifg_n = ifg_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // output registers are loaded from the next-cycle position so the
    // accepted byte appears one clock after its accept strobe
    always_comb begin
        status = INBAND_STATUS ? {full_duplex, spd_n, link_up} : 4'h0;
        nib    = half_n ? byte_n[7:4] : byte_n[3:0];
        rxc1_n = 1'b1;
        rxc2_n = 1'b0;
        rd1_n  = byte_n[3:0];
        rd2_n  = byte_n[7:4];
        ctl1_n = dv_n;
        ctl2_n = dv_n ^ er_n;
        if (!spd_n[1]) begin
            if (spd_n[0]) begin
                rxc1_n = (cnt_n <= 6'd2);
                rxc2_n = (cnt_n <= 6'd1);
            end else begin
                rxc1_n = (cnt_n < 6'd25);
                rxc2_n = (cnt_n < 6'd25);
            end
            rd1_n  = nib;
            rd2_n  = nib;
            ctl1_n = rxc1_n ? dv_n : (dv_n ^ er_n);
            ctl2_n = rxc2_n ? dv_n : (dv_n ^ er_n);
        end
        if (!dv_n) begin
            rd1_n  = status;
            rd2_n  = status;
            ctl1_n = 1'b0;
            ctl2_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            half_q    <= 1'b0;
            spd_q     <= 2'b10;
            byte_q    <= 8'd0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            ifg_q     <= 8'd0;
            run_q     <= 1'b0;
            rxc_d1    <= 1'b0;
            rxc_d2    <= 1'b0;
            rd_d1     <= 4'h0;
            rd_d2     <= 4'h0;
            rx_ctl_d1 <= 1'b0;
            rx_ctl_d2 <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            half_q    <= half_n;
            spd_q     <= spd_n;
            byte_q    <= byte_n;
            dv_q      <= dv_n;
            er_q      <= er_n;
            ifg_q     <= ifg_n;
            run_q     <= 1'b1;
            rxc_d1    <= rxc1_n;
            rxc_d2    <= rxc2_n;
            rd_d1     <= rd1_n;
            rd_d2     <= rd2_n;
            rx_ctl_d1 <= ctl1_n;
            rx_ctl_d2 <= ctl2_n;
        end
    end
endmodule
